lc3b_evict_buffer: RTL and testbench
====================================

# lc3b_evict_buffer

Parametrised eviction write buffer between the L1 and L2 caches. It absorbs dirty-line write-backs from L1 in a DEPTH-entry FIFO, so L1 can continue without waiting for L2. It serves L1 read misses from buffered lines when the address matches, and drains entries to L2 in the background. It generalises the fixed 16-bit address and 128-bit line widths to parameters, and adds write coalescing and an explicit flush.

## Interface
- ADDR_W, 16, line address width; the full width is compared.
- LINE_W, 128, cache line width in bits.
- DEPTH, 4, number of buffer entries; must be a power of two, ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- up_read  in  1  L1 line read request; held until up_resp.
- up_write  in  1  L1 eviction write request; held until up_resp.
- up_addr  in  ADDR_W  request line address.
- up_wdata  in  LINE_W  eviction data.
- up_rdata  out  LINE_W  read data; valid while up_resp=1.
- up_resp  out  1  one-cycle completion pulse.
- dn_read  out  1  L2 read request; held until dn_resp.
- dn_write  out  1  L2 write request; held until dn_resp.
- dn_addr  out  ADDR_W  L2 address.
- dn_wdata  out  LINE_W  L2 write data.
- dn_rdata  in  LINE_W  L2 read data; sampled when dn_resp=1.
- dn_resp  in  1  L2 completion pulse.
- flush  in  1  one-cycle pulse; drain all entries.
- flush_done  out  1  one-cycle pulse when the flush completes.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- count  out  $clog2(DEPTH+1)  number of valid entries.

## Operation
- Storage: circular FIFO with per-entry valid bit, addr and data. Head and tail pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- FSM states: IDLE, WR_ACK, RD_HIT, RD_MISS, DRAIN, FL_DONE.
- Dispatch in IDLE, by priority:
  1. flush_pending && !empty → DRAIN.
  2. flush_pending && empty → FL_DONE.
  3. up_read:
     - Address matches a valid entry → latch that entry's data, go to RD_HIT.
     - No match → RD_MISS.
  4. up_write:
     - Matches a valid entry → overwrite that entry's data in place (coalesce). Count is unchanged. Go to WR_ACK.
     - No match and !full → write at tail, tail++, count++, go to WR_ACK.
     - No match and full → DRAIN.
  5. No request and !empty → DRAIN.
- Only one entry can match, because coalescing guarantees unique addresses.
- up_read and up_write asserted together is illegal. Read takes priority; the write is serviced after the read's up_resp only if still held.
- WR_ACK: up_resp=1 for one cycle, then IDLE.
- RD_HIT: up_resp=1 and up_rdata=latched data for one cycle, then IDLE.
- RD_MISS:
  - Drive dn_read=1 and dn_addr=up_addr.
  - On dn_resp, latch dn_rdata and go to RD_HIT for the response.
  - A miss never allocates a buffer entry.
- DRAIN:
  - Drive dn_write=1 with the head entry's addr and data.
  - On dn_resp: clear the head valid bit, head++, count--, go to IDLE.
- flush:
  - A flush pulse sets flush_pending in any state.
  - FL_DONE: flush_done=1 for one cycle, clear flush_pending, go to IDLE.
  - A flush on an already-empty buffer produces flush_done two cycles later.
- Upstream requests are not serviced while flush_pending && !empty.
- Reset mid-operation:
  - All entries are discarded; buffered dirty data is lost by design.
  - dn_read and dn_write drop immediately, since reset is asynchronous.
- Reset values: every output is 0 except empty=1; state=IDLE; head, tail and count are 0; flush_pending=0.

## Timing
- All outputs are registered or decoded from state and registers. No combinational path runs from up_* to dn_*.
- Write accepted (not full), sampled in IDLE at cycle N: entry visible at N+1 and up_resp at N+1.
- The master deasserts its request at N+2. IDLE is re-entered at N+2.
- Read hit sampled at N: up_resp and up_rdata at N+1.
- Read miss sampled at N: dn_read asserted from N+1. dn_resp at cycle M gives up_resp at M+1.
- Drain started at N: dn_write asserted from N+1. dn_resp at M frees the entry at the M edge; IDLE at M+1.
- Write while full with no address match: latency = drain time + 2 cycles.
- A write that coalesces while full completes without a drain.

## Test plan
- After reset, write addresses 0x0010 and 0x0020 with no L2 activity → each up_resp arrives 1 cycle after the request is sampled; count=2.
- Read 0x0020 with data 0xA5…A5 buffered → up_resp after 1 cycle with data 0xA5…A5; dn_read never asserts.
- Write 0x0010 twice (data X then Y), then let it drain → exactly one dn_write for 0x0010, carrying Y.
- Fill 4 entries, then write 0x0050 with L2 latency 3 → head drains first; 0x0050 gets up_resp 6 cycles after its request; full deasserts when the head is freed.
- Read 0x0099 (a miss) with dn_rdata=0x1234… and 2-cycle L2 latency → dn_read for 0x0099; up_resp 1 cycle after dn_resp; count unchanged.
- Flush with 3 entries and L2 latency 1 → three dn_writes in FIFO order, one flush_done pulse, then empty=1. Assert rst_n=0 during the second dn_write → dn_write drops immediately; count=0; empty=1.

Source files
------------

// File: rtl/lc3b_evict_buffer.sv
// ---------------------------------------------------------------------------
// lc3b_evict_buffer
//
// Eviction write buffer sitting between L1 and L2. Dirty lines evicted by L1
// are parked in a DEPTH-entry circular FIFO so L1 is released after a single
// cycle. L1 read misses are served straight from the buffer on an address
// match, otherwise forwarded to L2. Buffered lines drain to L2 in the
// background whenever nothing else is pending. A write to an address that is
// already buffered overwrites the buffered line in place (coalescing), which
// keeps every buffered address unique. A flush pulse drains everything and
// reports completion with a flush_done pulse.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   up_read / up_write     L1 requests (held until up_resp)
//   up_addr, up_wdata      L1 request address / eviction data
//   up_rdata, up_resp      read data and one-cycle completion pulse to L1
//   dn_read / dn_write     L2 requests (held until dn_resp)
//   dn_addr, dn_wdata      L2 address / write data
//   dn_rdata, dn_resp      L2 read data and completion pulse
//   flush, flush_done      drain-all request pulse / completion pulse
//   full, empty, count     buffer occupancy
// ---------------------------------------------------------------------------
module lc3b_evict_buffer #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       up_read,
    input  logic                       up_write,
    input  logic [ADDR_W-1:0]          up_addr,
    input  logic [LINE_W-1:0]          up_wdata,
    output logic [LINE_W-1:0]          up_rdata,
    output logic                       up_resp,
    output logic                       dn_read,
    output logic                       dn_write,
    output logic [ADDR_W-1:0]          dn_addr,
    output logic [LINE_W-1:0]          dn_wdata,
    input  logic [LINE_W-1:0]          dn_rdata,
    input  logic                       dn_resp,
    input  logic                       flush,
    output logic                       flush_done,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ACK  = 3'd1,
        RD_HIT  = 3'd2,
        RD_MISS = 3'd3,
        DRAIN   = 3'd4,
        FL_DONE = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               flush_pending_q, flush_pending_d;
    logic [LINE_W-1:0]  rdata_q, rdata_d;
    logic [ADDR_W-1:0]  miss_addr_q, miss_addr_d;
    logic [DEPTH-1:0]   valid_q, valid_d;

    // Entry payload. Not reset: an entry is only meaningful while its valid
    // bit is set, and valid bits are cleared by reset.
    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [LINE_W-1:0]  data_q [DEPTH];

    logic               ent_we;
    logic [PTR_W-1:0]   ent_widx;

    logic [DEPTH-1:0]   match;
    logic               hit;
    logic [PTR_W-1:0]   hit_idx;
    logic               is_full;
    logic               is_empty;

    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);

    // Fully associative lookup over all valid entries.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = valid_q[gi] && (addr_q[gi] == up_addr);
        end
    endgenerate

    // Coalescing keeps addresses unique, so at most one match bit is set and
    // a plain priority encode is enough.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i]) begin
                hit_idx = PTR_W'(i);
            end
        end
    end
    assign hit = |match;

    // ---------------------------------------------------------------------
    // State and control registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            flush_pending_q <= 1'b0;
            rdata_q         <= '0;
            miss_addr_q     <= '0;
            valid_q         <= '0;
        end else begin
            state_q         <= state_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            flush_pending_q <= flush_pending_d;
            rdata_q         <= rdata_d;
            miss_addr_q     <= miss_addr_d;
            valid_q         <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ent_we) begin
            addr_q[ent_widx] <= up_addr;
            data_q[ent_widx] <= up_wdata;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and datapath update
    // ---------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        flush_pending_d = flush_pending_q;
        rdata_d         = rdata_q;
        miss_addr_d     = miss_addr_q;
        valid_d         = valid_q;
        ent_we          = 1'b0;
        ent_widx        = tail_q;

        case (state_q)
            IDLE: begin
                if (flush_pending_q && !is_empty) begin
                    state_d = DRAIN;
                end else if (flush_pending_q) begin
                    state_d = FL_DONE;
                end else if (up_read) begin
                    if (hit) begin
                        rdata_d = data_q[hit_idx];
                        state_d = RD_HIT;
                    end else begin
                        // Address is captured so dn_addr never depends
                        // combinationally on up_addr.
                        miss_addr_d = up_addr;
                        state_d     = RD_MISS;
                    end
                end else if (up_write) begin
                    if (hit) begin
                        ent_we   = 1'b1;
                        ent_widx = hit_idx;
                        state_d  = WR_ACK;
                    end else if (!is_full) begin
                        ent_we           = 1'b1;
                        ent_widx         = tail_q;
                        valid_d[tail_q]  = 1'b1;
                        tail_d           = tail_q + PTR_W'(1);
                        count_d          = count_q + CNT_W'(1);
                        state_d          = WR_ACK;
                    end else begin
                        // Make room; the write is re-evaluated back in IDLE.
                        state_d = DRAIN;
                    end
                end else if (!is_empty) begin
                    state_d = DRAIN;
                end
            end
            WR_ACK, RD_HIT: begin
                state_d = IDLE;
            end
            RD_MISS: begin
                if (dn_resp) begin
                    rdata_d = dn_rdata;
                    state_d = RD_HIT;
                end
            end
            DRAIN: begin
                if (dn_resp) begin
                    valid_d[head_q] = 1'b0;
                    head_d          = head_q + PTR_W'(1);
                    count_d         = count_q - CNT_W'(1);
                    state_d         = IDLE;
                end
            end
            FL_DONE: begin
                flush_pending_d = 1'b0;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new flush pulse always wins, even over the clear in FL_DONE.
        if (flush) begin
            flush_pending_d = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs, decoded from state and registers only
    // ---------------------------------------------------------------------
    always_comb begin
        up_resp    = (state_q == WR_ACK) || (state_q == RD_HIT);
        up_rdata   = (state_q == RD_HIT) ? rdata_q : '0;
        dn_read    = (state_q == RD_MISS);
        dn_write   = (state_q == DRAIN);
        dn_addr    = '0;
        dn_wdata   = '0;
        if (state_q == RD_MISS) begin
            dn_addr = miss_addr_q;
        end else if (state_q == DRAIN) begin
            dn_addr  = addr_q[head_q];
            dn_wdata = data_q[head_q];
        end
        flush_done = (state_q == FL_DONE);
        full       = is_full;
        empty      = is_empty;
        count      = count_q;
    end

endmodule

// File: tb/tb_lc3b_evict_buffer.sv
module tb_lc3b_evict_buffer;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clk;
    logic              rst_n;
    logic              up_read;
    logic              up_write;
    logic [ADDR_W-1:0] up_addr;
    logic [LINE_W-1:0] up_wdata;
    logic [LINE_W-1:0] up_rdata;
    logic              up_resp;
    logic              dn_read;
    logic              dn_write;
    logic [ADDR_W-1:0] dn_addr;
    logic [LINE_W-1:0] dn_wdata;
    logic [LINE_W-1:0] dn_rdata;
    logic              dn_resp;
    logic              flush;
    logic              flush_done;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;

    lc3b_evict_buffer #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_read    (up_read),
        .up_write   (up_write),
        .up_addr    (up_addr),
        .up_wdata   (up_wdata),
        .up_rdata   (up_rdata),
        .up_resp    (up_resp),
        .dn_read    (dn_read),
        .dn_write   (dn_write),
        .dn_addr    (dn_addr),
        .dn_wdata   (dn_wdata),
        .dn_rdata   (dn_rdata),
        .dn_resp    (dn_resp),
        .flush      (flush),
        .flush_done (flush_done),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    typedef struct {
        int                cyc;
        bit                chk_data;
        logic [LINE_W-1:0] data;
    } up_exp_t;

    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } dn_exp_t;

    up_exp_t up_q[$];
    dn_exp_t dn_q[$];
    int      fd_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    bit l2_en  = 1'b0;
    int l2_lat = 1;

    localparam logic [LINE_W-1:0] D10 = {8{16'h1010}};
    localparam logic [LINE_W-1:0] DA5 = {16{8'hA5}};
    localparam logic [LINE_W-1:0] DX  = {8{16'h5858}};
    localparam logic [LINE_W-1:0] DY  = {8{16'h5959}};
    localparam logic [LINE_W-1:0] D12 = {8{16'h1234}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // L2 model: dn_resp pulses l2_lat cycles after a request is first seen.
    initial begin : l2_model
        int cnt;
        cnt      = 0;
        dn_resp  = 1'b0;
        dn_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || dn_resp) begin
                dn_resp = 1'b0;
                cnt     = 0;
            end else if (l2_en && (dn_read || dn_write)) begin
                if (cnt == l2_lat) dn_resp = 1'b1;
                else               cnt++;
            end
        end
    end

    // Upstream response monitor.
    initial begin : mon_up
        up_exp_t e;
        forever begin
            @(negedge clk);
            if (up_resp) begin
                $display("up_resp cyc=%0d rdata=%h", cyc, up_rdata);
                if (up_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL up_unexpected: got up_resp at cyc %0d, required none", cyc);
                end else begin
                    e = up_q.pop_front();
                    check("up_resp_cycle", LINE_W'(cyc), LINE_W'(e.cyc));
                    if (e.chk_data) check("up_rdata", up_rdata, e.data);
                end
            end
        end
    end

    // Downstream transaction monitor: one compare per completed L2 access.
    initial begin : mon_dn
        dn_exp_t e;
        forever begin
            @(negedge clk);
            if (dn_resp && (dn_read || dn_write)) begin
                $display("L2 %s addr=%h wdata=%h cyc=%0d", dn_write ? "write" : "read",
                         dn_addr, dn_wdata, cyc);
                if (dn_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL dn_unexpected: got addr %h, required no transaction", dn_addr);
                end else begin
                    e = dn_q.pop_front();
                    check("dn_is_write", LINE_W'(dn_write), LINE_W'(e.wr));
                    check("dn_addr", LINE_W'(dn_addr), LINE_W'(e.addr));
                    if (e.wr) check("dn_wdata", dn_wdata, e.data);
                end
            end
        end
    end

    // flush_done monitor.
    initial begin : mon_fd
        int ec;
        forever begin
            @(negedge clk);
            if (flush_done) begin
                $display("flush_done cyc=%0d", cyc);
                if (fd_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL fd_unexpected: got flush_done at cyc %0d, required none", cyc);
                end else begin
                    ec = fd_q.pop_front();
                    check("flush_done_cycle", LINE_W'(cyc), LINE_W'(ec));
                end
            end
        end
    end

    task automatic push_dn(input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [LINE_W-1:0] d);
        dn_exp_t e;
        e.wr = wr; e.addr = a; e.data = d;
        dn_q.push_back(e);
    endtask

    // Waits for up_resp, then returns at the following posedge+1 with the
    // request still driven (the DUT is back in IDLE there).
    task automatic wait_resp();
        bit got;
        got = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (up_resp) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL up_resp_timeout: got no up_resp, required one within 60 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    // Must be called at posedge+1 while the DUT is in IDLE.
    task automatic issue(input bit rd, input logic [ADDR_W-1:0] a,
                         input logic [LINE_W-1:0] d, input int lat,
                         input logic [LINE_W-1:0] exp_d);
        up_exp_t e;
        e.cyc = cyc + lat; e.chk_data = rd; e.data = exp_d;
        up_q.push_back(e);
        up_read  = rd;
        up_write = !rd;
        up_addr  = a;
        up_wdata = d;
        wait_resp();
    endtask

    task automatic release_req();
        up_read  = 1'b0;
        up_write = 1'b0;
    endtask

    task automatic wait_empty();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (empty) break;
        end
        check("drained_empty", LINE_W'(empty), LINE_W'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_flush_done();
        bit got;
        got = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (flush_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL flush_done_timeout: got none, required a pulse within 60 cycles");
        end
    endtask

    initial begin : stim
        int p;
        rst_n    = 1'b0;
        up_read  = 1'b0;
        up_write = 1'b0;
        up_addr  = '0;
        up_wdata = '0;
        flush    = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_up_resp", LINE_W'(up_resp), LINE_W'(0));
        check("rst_up_rdata", up_rdata, '0);
        check("rst_dn_read", LINE_W'(dn_read), LINE_W'(0));
        check("rst_dn_write", LINE_W'(dn_write), LINE_W'(0));
        check("rst_dn_addr", LINE_W'(dn_addr), LINE_W'(0));
        check("rst_dn_wdata", dn_wdata, '0);
        check("rst_flush_done", LINE_W'(flush_done), LINE_W'(0));
        check("rst_full", LINE_W'(full), LINE_W'(0));
        check("rst_empty", LINE_W'(empty), LINE_W'(1));
        check("rst_count", LINE_W'(count), LINE_W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two writes, L2 silent; then a read hit; then coalescing writes.
        l2_en = 1'b0;
        issue(1'b0, 16'h0010, D10, 1, '0);
        issue(1'b0, 16'h0020, DA5, 1, '0);
        check("count_after_2_writes", LINE_W'(count), LINE_W'(2));
        issue(1'b1, 16'h0020, '0, 1, DA5);
        issue(1'b0, 16'h0010, DX, 1, '0);
        check("count_after_coalesce_x", LINE_W'(count), LINE_W'(2));
        issue(1'b0, 16'h0010, DY, 1, '0);
        check("count_after_coalesce_y", LINE_W'(count), LINE_W'(2));
        push_dn(1'b1, 16'h0010, DY);
        push_dn(1'b1, 16'h0020, DA5);
        release_req();
        l2_lat = 1;
        l2_en  = 1'b1;
        wait_empty();

        // Fill, then a non-matching write while full with L2 latency 3.
        l2_en = 1'b0;
        issue(1'b0, 16'h0030, {8{16'h3030}}, 1, '0);
        issue(1'b0, 16'h0040, {8{16'h4040}}, 1, '0);
        issue(1'b0, 16'h0060, {8{16'h6060}}, 1, '0);
        issue(1'b0, 16'h0070, {8{16'h7070}}, 1, '0);
        check("full_after_4", LINE_W'(full), LINE_W'(1));
        check("count_after_4", LINE_W'(count), LINE_W'(4));
        begin
            up_exp_t e;
            e.cyc = cyc + 6; e.chk_data = 1'b0; e.data = '0;
            up_q.push_back(e);
        end
        push_dn(1'b1, 16'h0030, {8{16'h3030}});
        l2_lat   = 3;
        l2_en    = 1'b1;
        up_write = 1'b1;
        up_addr  = 16'h0050;
        up_wdata = {8{16'h5050}};
        repeat (5) @(negedge clk);
        check("full_still_set_during_drain", LINE_W'(full), LINE_W'(1));
        @(negedge clk);
        check("full_clear_after_head_freed", LINE_W'(full), LINE_W'(0));
        check("count_after_head_freed", LINE_W'(count), LINE_W'(3));
        wait_resp();
        release_req();
        l2_lat = 1;
        push_dn(1'b1, 16'h0040, {8{16'h4040}});
        push_dn(1'b1, 16'h0060, {8{16'h6060}});
        push_dn(1'b1, 16'h0070, {8{16'h7070}});
        push_dn(1'b1, 16'h0050, {8{16'h5050}});
        wait_empty();

        // Read miss with L2 latency 2.
        l2_lat   = 2;
        dn_rdata = D12;
        push_dn(1'b0, 16'h0099, '0);
        issue(1'b1, 16'h0099, '0, 4, D12);
        release_req();
        @(negedge clk);
        check("count_after_miss", LINE_W'(count), LINE_W'(0));
        @(posedge clk); #1;

        // Flush with three entries, L2 latency 1.
        l2_en = 1'b0;
        issue(1'b0, 16'h00A0, {8{16'hA0A0}}, 1, '0);
        issue(1'b0, 16'h00B0, {8{16'hB0B0}}, 1, '0);
        issue(1'b0, 16'h00C0, {8{16'hC0C0}}, 1, '0);
        release_req();
        push_dn(1'b1, 16'h00A0, {8{16'hA0A0}});
        push_dn(1'b1, 16'h00B0, {8{16'hB0B0}});
        push_dn(1'b1, 16'h00C0, {8{16'hC0C0}});
        fd_q.push_back(cyc + 10);
        l2_lat = 1;
        l2_en  = 1'b1;
        flush  = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_flush_done();
        @(negedge clk);
        check("empty_after_flush", LINE_W'(empty), LINE_W'(1));
        @(posedge clk); #1;

        // Reset asserted during the second dn_write.
        l2_en = 1'b0;
        issue(1'b0, 16'h00D0, {8{16'hD0D0}}, 1, '0);
        issue(1'b0, 16'h00E0, {8{16'hE0E0}}, 1, '0);
        issue(1'b0, 16'h00F0, {8{16'hF0F0}}, 1, '0);
        release_req();
        push_dn(1'b1, 16'h00D0, {8{16'hD0D0}});
        l2_lat = 1;
        l2_en  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("second_dn_write_active", LINE_W'(dn_write), LINE_W'(1));
        check("second_dn_write_addr", LINE_W'(dn_addr), LINE_W'(16'h00E0));
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_drops_dn_write", LINE_W'(dn_write), LINE_W'(0));
        check("reset_count", LINE_W'(count), LINE_W'(0));
        check("reset_empty", LINE_W'(empty), LINE_W'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Flush on an empty buffer: flush_done two cycles later.
        p = cyc;
        fd_q.push_back(p + 2);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_flush_done();

        repeat (3) @(negedge clk);
        check("up_q_leftover", LINE_W'(up_q.size()), LINE_W'(0));
        check("dn_q_leftover", LINE_W'(dn_q.size()), LINE_W'(0));
        check("fd_q_leftover", LINE_W'(fd_q.size()), LINE_W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
